// File: rtl/irq_pending_capture.sv
// Interrupt pending capture with APB-style register access and edge/level qualification.
// Define IRQ_SYNC_EN to use a two-flop input synchronizer instead of a single input register.
module irq_pending_capture #(
   parameter int unsigned NO_OF_PERIPHERALS = 16,
   parameter int unsigned WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
   input  logic                         pclk_i,
   input  logic                         prst_i,
   input  logic [NO_OF_PERIPHERALS-1:0] irq_raw_i,
   input  logic                         pvalid_i,
   input  logic                         pwrite_en_i,
   input  logic [2:0]                   paddr_i,
   input  logic [NO_OF_PERIPHERALS-1:0] pwdata_i,
   output logic [NO_OF_PERIPHERALS-1:0] prdata_o,
   output logic                         pready_o,
   output logic [NO_OF_PERIPHERALS-1:0] interrupt_active_o,
   input  logic                         interrupt_serviced_i,
   input  logic [WIDTH-1:0]             interrupt_to_be_serviced_i
);

   localparam int unsigned N = NO_OF_PERIPHERALS;
`ifdef IRQ_SYNC_EN
   localparam int unsigned STAGES = 2;
`else
   localparam int unsigned STAGES = 1;
`endif

   logic [N-1:0]    enable_q, mode_q, pending_q, overflow_q;
   logic [N-1:0]    enable_d, mode_d, pending_d, overflow_d;
   logic [N-1:0]    s_q, p_q, prdata_q, prdata_d;
   logic            pready_q;
   logic [STAGES:0] warm_q;
`ifdef IRQ_SYNC_EN
   logic [N-1:0]    meta_q;
`endif

   logic            wr;
   logic [N-1:0]    rise, mode_chg, clear_vec, service_vec, pend_edge;

   // Input stage; warm_q marks when p has sampled a post-reset s, so a line
   // already high at reset release never looks like a rising edge.
   always_ff @(posedge pclk_i or negedge prst_i) begin
      if (!prst_i) begin
`ifdef IRQ_SYNC_EN
         meta_q <= '0;
`endif
         s_q    <= '0;
         p_q    <= '0;
         warm_q <= '0;
      end else begin
`ifdef IRQ_SYNC_EN
         meta_q <= irq_raw_i;
         s_q    <= meta_q;
`else
         s_q    <= irq_raw_i;
`endif
         p_q    <= s_q;
         warm_q <= {warm_q[STAGES-1:0], 1'b1};
      end
   end

   always_comb begin
      wr          = pvalid_i & pwrite_en_i;
      rise        = s_q & ~p_q & {N{warm_q[STAGES]}};
      enable_d    = (wr && paddr_i == 3'd0) ? pwdata_i : enable_q;
      mode_d      = (wr && paddr_i == 3'd1) ? pwdata_i : mode_q;
      mode_chg    = mode_d ^ mode_q;
      clear_vec   = (wr && paddr_i == 3'd3) ? pwdata_i : '0;
      service_vec = '0;
      if (interrupt_serviced_i && (32'(interrupt_to_be_serviced_i) < N)) begin
         service_vec[interrupt_to_be_serviced_i] = 1'b1;
      end
      // Set wins over clear/service in edge mode; level mode just follows s.
      pend_edge   = rise | (pending_q & ~(clear_vec | service_vec));
      pending_d   = ((mode_q & pend_edge) | (~mode_q & s_q)) & ~mode_chg;
      overflow_d  = ((mode_q & rise & pending_q) | (overflow_q & ~clear_vec)) & ~mode_chg;

      prdata_d = prdata_q;
      if (pvalid_i) begin
         case (paddr_i)
            3'd0:    prdata_d = enable_q;
            3'd1:    prdata_d = mode_q;
            3'd2:    prdata_d = pending_q;
            3'd4:    prdata_d = overflow_q;
            default: prdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge pclk_i or negedge prst_i) begin
      if (!prst_i) begin
         enable_q   <= '0;
         mode_q     <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         prdata_q   <= '0;
         pready_q   <= 1'b0;
      end else begin
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         prdata_q   <= prdata_d;
         pready_q   <= pvalid_i;
      end
   end

   assign prdata_o           = prdata_q;
   assign pready_o           = pready_q;
   assign interrupt_active_o = pending_q & enable_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
// Directed self-checking bench for irq_pending_capture (16 lines).
module tb_irq_pending_capture;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        pclk;
   logic        prst;
   logic [15:0] irq_raw;
   logic        pvalid, pwrite_en;
   logic [2:0]  paddr;
   logic [15:0] pwdata, prdata, active;
   logic        pready;
   logic        serviced;
   logic [3:0]  svc_idx;

   int          passed = 0;
   int          total  = 0;
   logic [15:0] rd;

   irq_pending_capture #(
      .NO_OF_PERIPHERALS(16),
      .WIDTH(4)
   ) dut (
      .pclk_i                    (pclk),
      .prst_i                    (prst),
      .irq_raw_i                 (irq_raw),
      .pvalid_i                  (pvalid),
      .pwrite_en_i               (pwrite_en),
      .paddr_i                   (paddr),
      .pwdata_i                  (pwdata),
      .prdata_o                  (prdata),
      .pready_o                  (pready),
      .interrupt_active_o        (active),
      .interrupt_serviced_i      (serviced),
      .interrupt_to_be_serviced_i(svc_idx)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
      pvalid = 1'b1; pwrite_en = 1'b1; paddr = a; pwdata = d;
      tick();
      pvalid = 1'b0; pwrite_en = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
      pvalid = 1'b1; pwrite_en = 1'b0; paddr = a;
      tick();
      d = prdata;
      pvalid = 1'b0;
   endtask

   initial begin
      prst = 1'b0; irq_raw = '0; pvalid = 1'b0; pwrite_en = 1'b0;
      paddr = '0; pwdata = '0; serviced = 1'b0; svc_idx = '0;

      // Reset with all lines toggled high
      #2 irq_raw = 16'hFFFF;
      repeat (3) tick();
      check("rst_active", active, 16'h0000);
      check("rst_prdata", prdata, 16'h0000);
      check("rst_pready", {15'b0, pready}, 16'h0000);
      prst = 1'b1;
      repeat (5) tick();
      apb_read(3'd2, rd);
      check("rst_level_pending", rd, 16'hFFFF);
      check("pready_after_read", {15'b0, pready}, 16'h0001);
      tick();
      check("pready_idle", {15'b0, pready}, 16'h0000);
      apb_write(3'd1, 16'hFFFF);
      repeat (4) tick();
      apb_read(3'd2, rd);
      check("rst_no_edge_pending", rd, 16'h0000);
      irq_raw = '0;
      repeat (4) tick();
      apb_write(3'd1, 16'h0000);

      // Edge capture and service on line 4
      apb_write(3'd0, 16'h0010);
      apb_write(3'd1, 16'h0010);
      irq_raw = 16'h0010;
      tick();
      irq_raw = '0;
      check("edge_early", active, 16'h0000);
      repeat (LAT) tick();
      check("edge_latency", active, 16'h0010);
      repeat (3) tick();
      check("edge_hold", active, 16'h0010);
      serviced = 1'b1; svc_idx = 4'd5;
      tick();
      check("service_other", active, 16'h0010);
      svc_idx = 4'd4;
      tick();
      serviced = 1'b0;
      check("service_hit", active, 16'h0000);

      // Level mode on line 0
      apb_write(3'd1, 16'h0000);
      apb_write(3'd0, 16'h0001);
      repeat (3) tick();
      for (int c = 0; c < 10; c++) begin
         irq_raw = (c < 5) ? 16'h0001 : 16'h0000;
         tick();
         check($sformatf("level_c%0d", c), active,
               (c >= LAT && c < 5 + LAT) ? 16'h0001 : 16'h0000);
      end
      irq_raw = 16'h0001;
      repeat (LAT + 2) tick();
      apb_write(3'd3, 16'h0001);
      check("level_clear_ignored", active, 16'h0001);
      irq_raw = '0;
      repeat (LAT + 2) tick();
      check("level_drop", active, 16'h0000);

      // Overflow on line 2
      apb_write(3'd1, 16'h0004);
      irq_raw = 16'h0004; tick(); irq_raw = '0;
      repeat (3) tick();
      irq_raw = 16'h0004; tick(); irq_raw = '0;
      repeat (3) tick();
      apb_read(3'd4, rd);
      check("overflow_set", rd, 16'h0004);
      apb_read(3'd2, rd);
      check("overflow_pending", rd, 16'h0004);
      apb_write(3'd3, 16'h0004);
      apb_read(3'd2, rd);
      check("clear_pending", rd, 16'h0000);
      apb_read(3'd4, rd);
      check("clear_overflow", rd, 16'h0000);
      apb_read(3'd3, rd);
      check("clear_reads_zero", rd, 16'h0000);
      apb_write(3'd5, 16'hFFFF);
      apb_read(3'd5, rd);
      check("addr5_reads_zero", rd, 16'h0000);
      apb_read(3'd0, rd);
      check("addr5_write_ignored", rd, 16'h0001);

      // Rise on line 7 coincident with CLEAR bit 7
      apb_write(3'd1, 16'h0084);
      irq_raw = 16'h0080;
      tick();
      irq_raw = '0;
      repeat (LAT - 1) tick();
      apb_write(3'd3, 16'h0080);
      apb_read(3'd2, rd);
      check("conflict_set_wins", rd, 16'h0080);

      // Masked edge on line 3
      apb_write(3'd1, 16'h0008);
      apb_write(3'd0, 16'h0000);
      irq_raw = 16'h0008; tick(); irq_raw = '0;
      repeat (LAT + 2) tick();
      check("mask_active", active, 16'h0000);
      apb_read(3'd2, rd);
      check("mask_pending", rd, 16'h0008);
      apb_write(3'd0, 16'h0008);
      check("unmask_active", active, 16'h0008);

      // Reset asserted mid-transfer
      pvalid = 1'b1; pwrite_en = 1'b1; paddr = 3'd0; pwdata = 16'hFFFF;
      #2 prst = 1'b0;
      #1;
      check("midrst_active", active, 16'h0000);
      tick();
      check("midrst_pready", {15'b0, pready}, 16'h0000);
      pvalid = 1'b0; pwrite_en = 1'b0;
      prst = 1'b1;
      tick();
      apb_read(3'd0, rd);
      check("midrst_enable", rd, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/irq_pending_capture.md
IRQ_PENDING_CAPTURE -- requirements
Module: irq_pending_capture

Interface
REQ-001 The module SHALL have the parameter NO_OF_PERIPHERALS, default 16, giving the number of interrupt lines.
REQ-002 The module SHALL have the parameter WIDTH, default $clog2(NO_OF_PERIPHERALS), giving the width of a line index.
REQ-003 The module SHALL have the port pclk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port prst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have the port irq_raw_i, input, NO_OF_PERIPHERALS bits: raw peripheral interrupt lines, asynchronous to pclk_i.
REQ-006 The module SHALL have the ports pvalid_i and pwrite_en_i, input, 1 bit each: APB transfer valid and write select.
REQ-007 The module SHALL have the port paddr_i, input, 3 bits: register select.
REQ-008 The module SHALL have the port pwdata_i, input, NO_OF_PERIPHERALS bits: write data.
REQ-009 The module SHALL have the port prdata_o, output, NO_OF_PERIPHERALS bits: registered read data.
REQ-010 The module SHALL have the port pready_o, output, 1 bit: registered transfer response.
REQ-011 The module SHALL have the port interrupt_active_o, output, NO_OF_PERIPHERALS bits: the qualified request vector to the downstream interrupt controller.
REQ-012 The module SHALL have the port interrupt_serviced_i, input, 1 bit: service-complete strobe from the downstream controller.
REQ-013 The module SHALL have the port interrupt_to_be_serviced_i, input, WIDTH bits: the index being serviced, qualified by interrupt_serviced_i.

Function
REQ-014 Registers SHALL be: addr 0 ENABLE (rw), 1 MODE (rw; 1=edge, 0=level), 2 PENDING (ro), 3 CLEAR (wo, write-1-to-clear, reads 0), 4 OVERFLOW (ro); addr 5-7 SHALL read 0 and ignore writes.
REQ-015 pready_o SHALL equal pvalid_i delayed one cycle; a write SHALL take effect, and prdata_o SHALL load, on the edge sampling pvalid_i=1; prdata_o SHALL hold between reads.
REQ-016 Each line SHALL pass through an input stage to produce a synchronized level s[i], plus a previous-sample register p[i]; rise[i] = s[i] & ~p[i].
REQ-017 Edge mode: PENDING[i] SHALL set on rise[i] and hold until cleared by a CLEAR write bit i or by interrupt_serviced_i=1 with interrupt_to_be_serviced_i=i.
REQ-018 Level mode: PENDING[i] SHALL equal s[i], registered each cycle; CLEAR and service strobes SHALL have no effect on it.
REQ-019 Simultaneous rise[i] and clear of line i SHALL leave PENDING[i]=1 (set wins).
REQ-020 rise[i] while PENDING[i]=1 in edge mode SHALL set OVERFLOW[i]; OVERFLOW[i] SHALL clear only via CLEAR write bit i, with set winning on a same-cycle conflict.
REQ-021 interrupt_active_o SHALL be combinational PENDING & ENABLE; disabled lines SHALL still latch PENDING.
REQ-022 A MODE change on line i SHALL clear PENDING[i] and OVERFLOW[i] on the same edge.
REQ-023 A service index >= NO_OF_PERIPHERALS SHALL be ignored.

Reset
REQ-024 On prst_i=0, ENABLE, MODE, PENDING, OVERFLOW, all synchronizer/previous registers, prdata_o and pready_o SHALL clear to 0 immediately; interrupt_active_o SHALL therefore be 0.
REQ-025 A line already high at reset release SHALL generate no rise (p[i] tracks s[i] from reset) and SHALL appear in level mode only.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no register update.

Configuration
REQ-027 With IRQ_SYNC_EN defined, the input stage SHALL be a two-flop synchronizer: raw high sampled at edge k gives s[i]=1 after edge k+1, PENDING=1 after edge k+2.
REQ-028 Without IRQ_SYNC_EN, the input stage SHALL be a single register: PENDING=1 after edge k+1; all other behaviour SHALL be identical.

Verification
REQ-029 Reset: hold prst_i=0, toggle irq_raw_i=16'hFFFF -> all outputs 0; release -> no pending in edge mode.
REQ-030 Edge capture: ENABLE=16'h0010, MODE=16'h0010, pulse irq_raw_i[4] one cycle -> interrupt_active_o=16'h0010 at the REQ-027/REQ-028 latency, held after irq drops; serviced strobe with index 4 -> 0 next cycle.
REQ-031 Level: MODE=0, ENABLE=16'h0001, irq_raw_i[0] high 5 cycles -> interrupt_active_o[0] high 5 cycles delayed by latency; CLEAR=16'h0001 has no effect.
REQ-032 Overflow: edge mode line 2, two pulses without clearing -> OVERFLOW read returns 16'h0004; CLEAR=16'h0004 -> PENDING and OVERFLOW both 0.
REQ-033 Conflict: rise on line 7 in the same cycle as CLEAR bit 7 -> PENDING[7]=1.
REQ-034 Masking: ENABLE=0, edge on line 3 -> interrupt_active_o=0 and PENDING=16'h0008; then ENABLE=16'h0008 -> interrupt_active_o=16'h0008.
